// File: rtl/csm_shared_mem.sv
// Two-port shared register file (4 x DATA_W) with a FREE/A_HELD/B_HELD lock; optional hold auto-release under CSM_HOLD_TIMEOUT_EN.
// Latency: every request is acked exactly one cycle later; no back-pressure, rejected commands are acked with err.
module csm_shared_mem #(
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [1:0]        a_op,
  input  logic [1:0]        a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic [1:0]        b_op,
  input  logic [1:0]        b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [1:0]        hold_owner
);

  typedef enum logic [1:0] {FREE = 2'b00, A_HELD = 2'b01, B_HELD = 2'b10} lock_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_HLD = 2'b10;
  localparam logic [1:0] OP_REL = 2'b11;

  if (HOLD_TIMEOUT < 1) begin : g_bad_timeout
    $error("HOLD_TIMEOUT must be at least 1");
  end

  lock_t             state, nstate;
  logic [DATA_W-1:0] mem [4];
  logic              a_acc, b_acc, a_bad, b_bad;
  logic              a_wr, b_wr, a_rd, b_rd;

  // Both commands are judged against the current lock state, so a same-cycle
  // release never unlocks the other port's command.
  always_comb begin
    a_acc = (state == FREE) || (state == A_HELD);
    b_acc = (state == FREE) || (state == B_HELD);
    a_bad = (a_op == OP_REL) ? (state != A_HELD) : !a_acc;
    unique case (b_op)
      OP_WR:   b_bad = !b_acc || (a_req && a_op == OP_WR && a_acc && a_addr == b_addr);
      OP_HLD:  b_bad = !b_acc || (state == FREE && a_req && a_op == OP_HLD);
      OP_REL:  b_bad = (state != B_HELD);
      default: b_bad = !b_acc;
    endcase
    a_wr = a_req && a_op == OP_WR && !a_bad;
    b_wr = b_req && b_op == OP_WR && !b_bad;
    a_rd = a_req && a_op == OP_RD && !a_bad;
    b_rd = b_req && b_op == OP_RD && !b_bad;
    nstate = state;
    if ((a_req && a_op == OP_REL && !a_bad) || (b_req && b_op == OP_REL && !b_bad))
      nstate = FREE;
    else if (state == FREE && a_req && a_op == OP_HLD)
      nstate = A_HELD;
    else if (state == FREE && b_req && b_op == OP_HLD)
      nstate = B_HELD;
  end

`ifdef CSM_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          holder_req, timeout;
  assign holder_req = (state == A_HELD && a_req) || (state == B_HELD && b_req);
  assign timeout    = (state != FREE) && !holder_req && (timer == TW'(HOLD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timeout || holder_req || state == FREE || nstate == FREE) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FREE;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      state <= timeout ? FREE : nstate;
      a_ack <= a_req;
      b_ack <= b_req;
      a_err <= a_req && a_bad;
      b_err <= b_req && b_bad;
      if (a_rd) a_rdata <= mem[a_addr];
      if (b_rd) b_rdata <= mem[b_addr];
      if (a_wr) mem[a_addr] <= a_wdata;
      if (b_wr) mem[b_addr] <= b_wdata;
    end
  end

  assign hold_owner = state;

endmodule

// File: tb/tb_csm_shared_mem.sv
// Scoreboard bench for csm_shared_mem: directed scenarios then randomized traffic against a rule-level model.
module tb_csm_shared_mem;
  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req;
  logic [1:0] a_op, b_op, a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack, a_err, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic [1:0] hold_owner;

  csm_shared_mem #(.DATA_W(8), .HOLD_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .hold_owner(hold_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       a_ack, a_err, b_ack, b_err;
    bit [7:0] a_rd, b_rd;
    bit [1:0] owner;
  } exp_t;

  exp_t     sb[$];
  int       tests = 0;
  int       fails = 0;

  // Reference model: registers, lock owner (0 none, 1 A, 2 B), idle count
  bit [7:0] m_mem[4];
  int       m_owner;
  int       m_idle;
  bit [7:0] m_ard, m_brd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit may_use(int p);
    return (m_owner == 0) || (m_owner == p);
  endfunction

  task automatic step(input bit rst,
                      input bit ar, input bit [1:0] ao, input bit [1:0] aa, input bit [7:0] ad,
                      input bit br, input bit [1:0] bo, input bit [1:0] ba, input bit [7:0] bd);
    exp_t e;
    bit   a_ok, b_ok, hold_req;
    int   pre;
    @(negedge clk);
    reset = rst;
    a_req = ar; a_op = ao; a_addr = aa; a_wdata = ad;
    b_req = br; b_op = bo; b_addr = ba; b_wdata = bd;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_owner = 0; m_idle = 0; m_ard = 8'h00; m_brd = 8'h00;
      e = '{a_ack: 0, a_err: 0, b_ack: 0, b_err: 0, a_rd: 0, b_rd: 0, owner: 0};
      sb.push_back(e);
      return;
    end
    pre  = m_owner;
    a_ok = (ao == 2'd3) ? (pre == 1) : may_use(1);
    case (bo)
      2'd1:    b_ok = may_use(2) && !(ar && ao == 2'd1 && a_ok && aa == ba);
      2'd2:    b_ok = may_use(2) && !(pre == 0 && ar && ao == 2'd2);
      2'd3:    b_ok = (pre == 2);
      default: b_ok = may_use(2);
    endcase
    if (ar && ao == 2'd0 && a_ok) m_ard = m_mem[aa];
    if (br && bo == 2'd0 && b_ok) m_brd = m_mem[ba];
    if (ar && ao == 2'd1 && a_ok) m_mem[aa] = ad;
    if (br && bo == 2'd1 && b_ok) m_mem[ba] = bd;
    if ((ar && ao == 2'd3 && a_ok) || (br && bo == 2'd3 && b_ok)) m_owner = 0;
    else if (pre == 0 && ar && ao == 2'd2) m_owner = 1;
    else if (pre == 0 && br && bo == 2'd2 && b_ok) m_owner = 2;
    hold_req = (pre == 1 && ar) || (pre == 2 && br);
`ifdef CSM_HOLD_TIMEOUT_EN
    if (pre != 0 && m_owner != 0 && !hold_req) begin
      m_idle++;
      if (m_idle == 16) begin m_owner = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
`else
    m_idle = hold_req ? 0 : m_idle;
`endif
    e.a_ack = ar; e.a_err = ar && !a_ok; e.a_rd = m_ard;
    e.b_ack = br; e.b_err = br && !b_ok; e.b_rd = m_brd;
    e.owner = 2'(m_owner);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: each cycle's DUT response is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_ack", 32'(a_ack), 32'(e.a_ack));
        chk("b_ack", 32'(b_ack), 32'(e.b_ack));
        if (e.a_ack) chk("a_err", 32'(a_err), 32'(e.a_err));
        if (e.b_ack) chk("b_err", 32'(b_err), 32'(e.b_err));
        chk("a_rdata", 32'(a_rdata), 32'(e.a_rd));
        chk("b_rdata", 32'(b_rdata), 32'(e.b_rd));
        chk("hold_owner", 32'(hold_owner), 32'(e.owner));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2'd1, 2'd1, 8'h77, 1, 2'd2, 0, 0);  // requests dropped under reset
    // write then read back across ports
    step(0, 1, 2'd1, 2'd2, 8'hA5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0);
    // hold blocks the other port until release
    step(0, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0);
    step(0, 1, 2'd3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0);
    // simultaneous holds, then release while B tries to write
    step(0, 1, 2'd2, 0, 0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd3, 0, 0, 1, 2'd1, 2'd0, 8'h11);
    step(0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
    // same-address write collision
    step(0, 1, 2'd1, 2'd3, 8'hFF, 1, 2'd1, 2'd3, 8'h00);
    step(0, 1, 2'd0, 2'd3, 0, 0, 0, 0, 0);
    // read-old on same-cycle read/write
    step(0, 1, 2'd1, 2'd0, 8'h3C, 1, 2'd0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    // B holds, A locked out, B releases
    step(0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd1, 2'd1, 8'h42, 1, 2'd1, 2'd1, 8'h24);
    step(0, 1, 2'd2, 0, 0, 1, 2'd2, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
    // hold left idle: times out when enabled, persists otherwise
    step(0, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    idle(17);
    step(0, 0, 0, 0, 0, 1, 2'd1, 2'd2, 8'h5A);
    step(0, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 2'd0, 2'(i), 0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(9) < 7, 2'($urandom), 2'($urandom), 8'($urandom),
           $urandom_range(9) < 7, 2'($urandom), 2'($urandom), 8'($urandom));
    end
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
